// File: rtl/counter_address_register.sv
`default_nettype none
// ============================================================================
//  Module   : counter_address_register
//  Brief    : Loadable up/down counter register for program counter, stack
//             and pointer registers. It loads from the shared tri-state data
//             bus and counts once on each rising edge of the inc/dec strobes.
//             It can drive its value onto the data bus and the address bus,
//             each through its own active-low enable.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_address_register #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  inout  wire  [WIDTH-1:0] Bus,
  output wire  [WIDTH-1:0] Addr,
  input  logic             load_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             a_bus_n,
  input  logic             a_addr_n
);

  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_value;
  logic             r_inc_prev;
  logic             r_dec_prev;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_data;
  logic             w_inc_rise;
  logic             w_dec_rise;

  // A strobe counts only on a 0->1 transition seen across two clock edges.
  assign w_inc_rise = inc & ~r_inc_prev;
  assign w_dec_rise = dec & ~r_dec_prev;

  // While we drive Bus ourselves, a load would capture our own value, so take
  // it straight from the register instead of reading it back through the pad.
  assign w_load_data = a_bus_n ? Bus : r_value;

  // Next-value selection: load beats counting, and opposing edges cancel.
  always_comb begin
    w_next = r_value;
    if (!load_n) begin
      w_next = w_load_data;
    end else if (w_inc_rise && w_dec_rise) begin
      w_next = r_value;
    end else if (w_inc_rise) begin
      w_next = r_value + C_ONE;
    end else if (w_dec_rise) begin
      w_next = r_value - C_ONE;
    end
  end

  // Value register and strobe history. The history resets to 1 so that a
  // strobe already high when clear is released is not counted.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_value    <= C_ZERO;
      r_inc_prev <= 1'b1;
      r_dec_prev <= 1'b1;
    end else begin
      r_value    <= w_next;
      r_inc_prev <= inc;
      r_dec_prev <= dec;
    end
  end

  // Tri-state drivers follow their enables only, independent of clear.
  assign Bus  = a_bus_n  ? {WIDTH{1'bz}} : r_value;
  assign Addr = a_addr_n ? {WIDTH{1'bz}} : r_value;

endmodule
`default_nettype wire

// File: tb/tb_counter_address_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_address_register
//  Brief    : Self-checking bench for counter_address_register. A behavioural
//             model tracks the register value as a modular sum of counted
//             strobe edges and bus loads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_address_register;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] C_PULLED = {WIDTH{1'b1}};

  logic             clock = 1'b0;
  logic             clear;
  logic             load_n;
  logic             inc;
  logic             dec;
  logic             a_bus_n;
  logic             a_addr_n;
  logic [WIDTH-1:0] tb_bus;
  logic             tb_en;

  wire  [WIDTH-1:0] Bus;
  wire  [WIDTH-1:0] Addr;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_val;
  logic             m_inc_last;
  logic             m_dec_last;

  // The bench only drives Bus while the DUT is not allowed to.
  assign Bus = (tb_en && a_bus_n) ? tb_bus : {WIDTH{1'bz}};

  pullup (Bus);
  pullup (Addr);

  counter_address_register #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .clear    (clear),
    .Bus      (Bus),
    .Addr     (Addr),
    .load_n   (load_n),
    .inc      (inc),
    .dec      (dec),
    .a_bus_n  (a_bus_n),
    .a_addr_n (a_addr_n)
  );

  always #5 clock = ~clock;

  // Advance one clock edge and apply the reference rules to the model.
  task automatic cycle();
    logic [WIDTH-1:0] ups;
    logic [WIDTH-1:0] downs;
    @(posedge clock);
    if (clear) begin
      m_val      = '0;
      m_inc_last = 1'b1;
      m_dec_last = 1'b1;
    end else begin
      ups   = WIDTH'(inc && !m_inc_last);
      downs = WIDTH'(dec && !m_dec_last);
      if (!load_n) begin
        if (a_bus_n) m_val = tb_en ? tb_bus : C_PULLED;
      end else begin
        m_val = m_val + ups - downs;
      end
      m_inc_last = inc;
      m_dec_last = dec;
    end
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; tb_bus = 16'hAAAA; tb_en = 1'b1; load_n = 1'b0;
    inc = 1'b1; dec = 1'b1; a_bus_n = 1'b1; a_addr_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++;
      if (Addr !== 16'h0000) begin
        bad++; $display("FAIL reset_hold cyc=%0d Addr=%h expected=%h", i, Addr, 16'h0000);
      end
    end
  endtask

  task automatic test_load();
    @(negedge clock);
    clear = 1'b0;
    cycle();
    cycle();
    load_n = 1'b1; tb_en = 1'b0;
    cycle();
    total++;
    if (Addr !== 16'hAAAA) begin
      bad++; $display("FAIL load_addr Addr=%h expected=%h", Addr, 16'hAAAA);
    end
    total++;
    if (Bus !== C_PULLED) begin
      bad++; $display("FAIL bus_hiz Bus=%h expected=%h", Bus, C_PULLED);
    end
    a_bus_n = 1'b0; #1;
    total++;
    if (Bus !== 16'hAAAA) begin
      bad++; $display("FAIL load_bus Bus=%h expected=%h", Bus, 16'hAAAA);
    end
    a_bus_n = 1'b1; a_addr_n = 1'b1; #1;
    total++;
    if (Addr !== C_PULLED) begin
      bad++; $display("FAIL addr_hiz Addr=%h expected=%h", Addr, C_PULLED);
    end
    a_addr_n = 1'b0;
  endtask

  task automatic test_strobes();
    for (int p = 0; p < 2; p++) begin
      dec = 1'b0; repeat (3) cycle();
      dec = 1'b1; repeat (3) cycle();
    end
    total++;
    if (Addr !== 16'hAAA8 || m_val !== 16'hAAA8) begin
      bad++; $display("FAIL dec_pulses Addr=%h model=%h expected=%h", Addr, m_val, 16'hAAA8);
    end
    for (int p = 0; p < 3; p++) begin
      inc = 1'b0; repeat (2) cycle();
      inc = 1'b1; repeat (4) cycle();
    end
    a_bus_n = 1'b0; #1;
    total++;
    if (Bus !== 16'hAAAB || Addr !== 16'hAAAB) begin
      bad++; $display("FAIL inc_pulses Bus=%h Addr=%h expected=%h", Bus, Addr, 16'hAAAB);
    end
    a_bus_n = 1'b1;
  endtask

  task automatic test_wrap();
    tb_bus = 16'hFFFF; tb_en = 1'b1; load_n = 1'b0;
    cycle();
    load_n = 1'b1; tb_en = 1'b0;
    inc = 1'b0; cycle();
    inc = 1'b1; cycle();
    total++;
    if (Addr !== 16'h0000) begin
      bad++; $display("FAIL wrap_up Addr=%h expected=%h", Addr, 16'h0000);
    end
    dec = 1'b0; cycle();
    dec = 1'b1; cycle();
    total++;
    if (Addr !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_down Addr=%h expected=%h", Addr, 16'hFFFF);
    end
  endtask

  task automatic test_simultaneous();
    inc = 1'b0; dec = 1'b0; cycle();
    inc = 1'b1; dec = 1'b1; cycle();
    total++;
    if (Addr !== 16'hFFFF) begin
      bad++; $display("FAIL both_edges Addr=%h expected=%h", Addr, 16'hFFFF);
    end
    inc = 1'b0; cycle();
    tb_bus = 16'h1234; tb_en = 1'b1; load_n = 1'b0; inc = 1'b1;
    cycle();
    load_n = 1'b1; tb_en = 1'b0;
    cycle();
    total++;
    if (Addr !== 16'h1234) begin
      bad++; $display("FAIL load_beats_inc Addr=%h expected=%h", Addr, 16'h1234);
    end
    // Release clear with inc already high: no count may follow.
    inc = 1'b0; cycle();
    clear = 1'b1; cycle();
    inc = 1'b1; cycle();
    clear = 1'b0;
    repeat (3) cycle();
    total++;
    if (Addr !== 16'h0000) begin
      bad++; $display("FAIL release_with_inc Addr=%h expected=%h", Addr, 16'h0000);
    end
  endtask

  task automatic test_async_clear();
    tb_bus = 16'h5555; tb_en = 1'b1; load_n = 1'b0;
    cycle();
    tb_en = 1'b0; a_bus_n = 1'b0;
    cycle();
    load_n = 1'b1;
    total++;
    if (Bus !== 16'h5555 || Addr !== 16'h5555) begin
      bad++; $display("FAIL load_while_driving Bus=%h Addr=%h expected=%h", Bus, Addr, 16'h5555);
    end
    a_bus_n = 1'b1;
    cycle();
    #2 clear = 1'b1;
    #1;
    total++;
    if (Addr !== 16'h0000) begin
      bad++; $display("FAIL async_clear Addr=%h expected=%h", Addr, 16'h0000);
    end
    cycle();
    clear = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_addr;
    for (int i = 0; i < 400; i++) begin
      inc      = 1'($urandom_range(0, 1));
      dec      = 1'($urandom_range(0, 1));
      load_n   = ($urandom_range(0, 7) != 0);
      a_bus_n  = ($urandom_range(0, 3) != 0);
      a_addr_n = ($urandom_range(0, 5) == 0);
      clear    = ($urandom_range(0, 49) == 0);
      tb_bus   = WIDTH'($urandom);
      tb_en    = 1'b1;
      cycle();
      exp_addr = a_addr_n ? C_PULLED : m_val;
      total++;
      if (Addr !== exp_addr) begin
        bad++; $display("FAIL rand_addr i=%0d Addr=%h expected=%h", i, Addr, exp_addr);
      end
      if (!a_bus_n) begin
        total++;
        if (Bus !== m_val) begin
          bad++; $display("FAIL rand_bus i=%0d Bus=%h expected=%h", i, Bus, m_val);
        end
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b1; load_n = 1'b1; inc = 1'b1; dec = 1'b1;
    a_bus_n = 1'b1; a_addr_n = 1'b0; tb_bus = '0; tb_en = 1'b0;
    m_val = '0; m_inc_last = 1'b1; m_dec_last = 1'b1;
    test_reset();
    test_load();
    test_strobes();
    test_wrap();
    test_simultaneous();
    test_async_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_address_register.md
Name: counter_address_register

Overview:
- 16-bit loadable up/down counter register for the pipelined CPU, used for program counter, stack and pointer registers.
- Loads from the shared tri-state data Bus.
- Counts up or down on rising edges of separate inc/dec strobes.
- Can independently drive its value onto the shared Bus and onto the address bus (Addr), each through its own active-low tri-state enable.

Parameters:
WIDTH, 16, register/bus width in bits.

Ports:
clock  input  1  system clock; all state changes except clear occur on its rising edge.
clear  input  1  reset; asynchronous, active-high; forces register to 0.
Bus  inout  WIDTH  shared data bus; sampled on load, driven when a_bus_n=0, else high-Z.
Addr  output  WIDTH  address bus output; driven when a_addr_n=0, else high-Z.
load_n  input  1  active-low synchronous load enable from Bus.
inc  input  1  increment strobe; one count per 0->1 transition.
dec  input  1  decrement strobe; one count per 0->1 transition.
a_bus_n  input  1  active-low output enable onto Bus.
a_addr_n  input  1  active-low output enable onto Addr.

Behaviour:
- State: value register (WIDTH bits), inc_prev and dec_prev (1 bit each).
- Reset: clear=1 asynchronously sets value=0 and inc_prev=dec_prev=1.
  - Clear is held for as long as it is asserted.
  - load_n, inc and dec are ignored while clear=1.
  - Reset does not affect the tri-state outputs, which follow their enables. If enabled during reset, the outputs drive 0.
- Edge detection, on each clock rising edge with clear=0:
  - inc_rise = inc & ~inc_prev; dec_rise = dec & ~dec_prev.
  - inc_prev <= inc; dec_prev <= dec.
  - Because the prev bits reset to 1, releasing clear while a strobe is already high does not count.
- Update priority, on each clock rising edge with clear=0:
  1. load_n=0: value <= Bus.
  2. Else if inc_rise and dec_rise are both set: value unchanged.
  3. Else if inc_rise: value <= value+1, modulo 2^WIDTH (0xFFFF -> 0x0000).
  4. Else if dec_rise: value <= value-1, modulo 2^WIDTH (0x0000 -> 0xFFFF).
  5. Else: hold.
- Count latency: the strobe's 0->1 transition must be present at a clock rising edge. The new value is visible after that edge. A strobe held at 0 or at 1 for many cycles produces exactly one count per 0->1 transition.
- Outputs, purely combinational from the enables:
  - Bus = a_bus_n ? Z : value.
  - Addr = a_addr_n ? Z : value.
  - Both enables may be low at once; both buses are then driven.
- Load while driving Bus (load_n=0 and a_bus_n=0): the register reloads its own value, i.e. holds. This is legal, not an error.
- Bus is never driven by this block while a_bus_n=1, including during reset.

Test Plan:
1. clear=1, Bus=0xAAAA, load_n=0 for several clocks -> value stays 0x0000; with a_addr_n=0, Addr=0x0000.
2. Release clear, load_n=0 with Bus=0xAAAA for one or more clocks, then load_n=1 and release Bus -> value 0xAAAA. Strobe a_bus_n=0 -> Bus=0xAAAA; strobe a_addr_n=0 -> Addr=0xAAAA. Each is high-Z when its enable is 1.
3. From 0xAAAA, pulse dec 1->0->1 twice, each low phase spanning multiple clocks -> 0xAAA8 (one count per rising edge). Then pulse inc three times -> 0xAAAB. Drive onto Bus and Addr to confirm 0xAAAB.
4. Wrap-around: load 0xFFFF, one inc pulse -> 0x0000; one dec pulse -> 0xFFFF.
5. Simultaneous events:
   - Rising edges of inc and dec in the same cycle -> unchanged.
   - load_n=0 with an inc rising edge in the same cycle, Bus=0x1234 -> 0x1234.
   - Release clear while inc=1 -> no count.
6. Asynchronous clear mid-operation: value 0x5555, assert clear between clock edges -> value 0x0000 immediately (Addr=0x0000 with a_addr_n=0, before the next clock edge).
